frame_scan_controller: RTL and testbench

FRAME_SCAN_CONTROLLER -- requirements
Module: frame_scan_controller

---
 rtl/frame_scan_controller.sv | 124 ++++++++++++
 tb/tb_frame_scan_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scan_controller.sv
// Raster scan sequencer: walks a frame line by line and emits one pixel beat per
// valid/ready handshake, with horizontal blanking between lines.
module frame_scan_controller #(
  parameter int IMG_WIDTH  = 400,
  parameter int IMG_HEIGHT = 300,
  parameter int HBLANK     = 16,
  parameter int COORD_W    = 12
) (
  input  logic               pixclk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               ready,
  output logic               valid,
  output logic [COORD_W-1:0] x_coord,
  output logic [COORD_W-1:0] y_coord,
  output logic               sof,
  output logic               eol,
  output logic               eof,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        frame_count
);

  localparam int BLANK_W = (HBLANK > 1) ? $clog2(HBLANK) : 1;
  localparam logic [BLANK_W-1:0] BLANK_LAST = (HBLANK > 0) ? BLANK_W'(HBLANK - 1) : '0;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_HBLANK,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic [15:0]        frame_count_q, frame_count_d;

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    blank_d       = blank_q;
    frame_count_d = frame_count_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (ready) begin
          if (x_q != X_LAST) begin
            x_d = x_q + 1'b1;
          end else begin
            x_d = '0;
            if (y_q != Y_LAST) begin
              y_d     = y_q + 1'b1;
              blank_d = '0;
              state_d = (HBLANK == 0) ? S_ACTIVE : S_HBLANK;
            end else begin
              y_d     = '0;
              state_d = S_DONE;
            end
          end
        end
      end
      S_HBLANK: begin
        if (blank_q == BLANK_LAST) begin
          blank_d = '0;
          state_d = S_ACTIVE;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d       = S_IDLE;
        frame_count_d = frame_count_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything above, including the completion count in DONE.
    if (abort && state_q != S_IDLE) begin
      state_d       = S_IDLE;
      x_d           = '0;
      y_d           = '0;
      blank_d       = '0;
      frame_count_d = frame_count_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others; reset is synchronous to pixclk.
  always_ff @(posedge pixclk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      blank_q       <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      blank_q       <= blank_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign valid       = (state_q == S_ACTIVE);
  assign x_coord     = x_q;
  assign y_coord     = y_q;
  assign sof         = valid && (x_q == '0) && (y_q == '0);
  assign eol         = valid && (x_q == X_LAST);
  assign eof         = eol && (y_q == Y_LAST);
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = (state_q == S_DONE);
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_scan_controller.sv
// Table-driven bench for frame_scan_controller on a 4x3 frame with 2 blank cycles;
// each vector's expected response is queued on drive and compared one cycle later.
module tb_frame_scan_controller;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int HB = 2;
  localparam int CW = 12;
  localparam int LINE_CYC  = W + HB;
  localparam int FRAME_CYC = W * H + HB * (H - 1);

  logic          pixclk = 1'b0;
  logic          reset  = 1'b1;
  logic          start  = 1'b0;
  logic          abort  = 1'b0;
  logic          ready  = 1'b1;
  logic          valid;
  logic [CW-1:0] x_coord;
  logic [CW-1:0] y_coord;
  logic          sof, eol, eof, busy, frame_done;
  logic [15:0]   frame_count;

  frame_scan_controller #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .HBLANK    (HB),
    .COORD_W   (CW)
  ) dut (
    .pixclk     (pixclk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .ready      (ready),
    .valid      (valid),
    .x_coord    (x_coord),
    .y_coord    (y_coord),
    .sof        (sof),
    .eol        (eol),
    .eof        (eof),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  always #5 pixclk = ~pixclk;

  typedef struct packed {
    logic          valid;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          sof;
    logic          eol;
    logic          eof;
    logic          busy;
    logic          frame_done;
    logic [15:0]   fc;
  } out_t;

  typedef struct packed {
    logic reset;
    logic start;
    logic abort;
    logic ready;
  } in_t;

  // relax: the DONE cycle leaves coordinates and frame_count timing open.
  typedef struct {
    out_t  o;
    logic  relax;
    string tag;
    int    cyc;
  } exp_t;

  typedef struct {
    in_t  in;
    exp_t e;
  } vec_t;

  int   n_vec    = 0;
  int   n_miss   = 0;
  int   beat_cnt = 0;
  int   done_cnt = 0;
  exp_t sb[$];
  vec_t vecs[$];

  function automatic in_t mk_in(logic r, logic s, logic a, logic rd);
    in_t i;
    i.reset = r;
    i.start = s;
    i.abort = a;
    i.ready = rd;
    return i;
  endfunction

  function automatic out_t idle_out(logic [15:0] fc);
    out_t o = '0;
    o.fc = fc;
    return o;
  endfunction

  function automatic out_t beat_out(int x, int y, logic [15:0] fc);
    out_t o = '0;
    o.valid = 1'b1;
    o.busy  = 1'b1;
    o.x     = CW'(x);
    o.y     = CW'(y);
    o.sof   = (x == 0) && (y == 0);
    o.eol   = (x == W - 1);
    o.eof   = (x == W - 1) && (y == H - 1);
    o.fc    = fc;
    return o;
  endfunction

  // Outputs in cycle c of an unstalled frame whose start was sampled in cycle 0.
  function automatic exp_t nominal(int c, logic [15:0] fc, string tag, int cyc);
    exp_t e;
    int   line, pos;
    e.relax = 1'b0;
    e.tag   = tag;
    e.cyc   = cyc;
    if (c < 1) begin
      e.o = idle_out(fc);
    end else if (c <= FRAME_CYC) begin
      line = (c - 1) / LINE_CYC;
      pos  = (c - 1) % LINE_CYC;
      if (pos < W) begin
        e.o = beat_out(pos, line, fc);
      end else begin
        e.o      = '0;
        e.o.busy = 1'b1;
        e.o.y    = CW'(line + 1);
        e.o.fc   = fc;
      end
    end else if (c == FRAME_CYC + 1) begin
      e.o            = '0;
      e.o.busy       = 1'b1;
      e.o.frame_done = 1'b1;
      e.relax        = 1'b1;
    end else begin
      e.o = idle_out(fc + 16'd1);
    end
    return e;
  endfunction

  function automatic exp_t idle_exp(logic [15:0] fc, string tag, int cyc);
    exp_t e;
    e.o     = idle_out(fc);
    e.relax = 1'b0;
    e.tag   = tag;
    e.cyc   = cyc;
    return e;
  endfunction

  function automatic out_t cur_out();
    out_t o;
    o.valid      = valid;
    o.x          = x_coord;
    o.y          = y_coord;
    o.sof        = sof;
    o.eol        = eol;
    o.eof        = eof;
    o.busy       = busy;
    o.frame_done = frame_done;
    o.fc         = frame_count;
    return o;
  endfunction

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    out_t a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = cur_out();
      if (e.relax) begin
        a.x    = '0;
        a.y    = '0;
        a.fc   = '0;
        e.o.x  = '0;
        e.o.y  = '0;
        e.o.fc = '0;
      end
      n_vec++;
      if (a !== e.o) begin
        n_miss++;
        $display("FAIL %s cycle %0d: got v=%b x=%0d y=%0d sof=%b eol=%b eof=%b busy=%b done=%b fc=%0d, expected v=%b x=%0d y=%0d sof=%b eol=%b eof=%b busy=%b done=%b fc=%0d",
                 e.tag, e.cyc, a.valid, a.x, a.y, a.sof, a.eol, a.eof, a.busy, a.frame_done, a.fc,
                 e.o.valid, e.o.x, e.o.y, e.o.sof, e.o.eol, e.o.eof, e.o.busy, e.o.frame_done, e.o.fc);
      end
    end
  endtask

  // Mid-cycle: score last cycle's response, then drive this cycle's inputs.
  task automatic apply(in_t in, exp_t e, logic push);
    @(negedge pixclk);
    compare_front();
    if (valid === 1'b1 && in.ready && !in.reset) beat_cnt++;
    if (frame_done === 1'b1) done_cnt++;
    reset = in.reset;
    start = in.start;
    abort = in.abort;
    ready = in.ready;
    if (push) sb.push_back(e);
  endtask

  task automatic run_vectors();
    exp_t dummy;
    dummy = idle_exp(16'd0, "flush", 0);
    foreach (vecs[i]) apply(vecs[i].in, vecs[i].e, 1'b1);
    apply(mk_in(1'b0, 1'b0, 1'b0, 1'b1), dummy, 1'b0);
    vecs.delete();
  endtask

  task automatic add(in_t in, exp_t e);
    vec_t v;
    v.in = in;
    v.e  = e;
    vecs.push_back(v);
  endtask

  initial begin
    int b0, d0, c, ec;

    for (int i = 0; i < 2; i++)
      add(mk_in(1'b1, 1'b0, 1'b0, 1'b1), idle_exp(16'd0, "reset", i + 1));
    run_vectors();

    for (int i = 0; i <= FRAME_CYC + 2; i++)
      add(mk_in(1'b0, i == 0, 1'b0, 1'b1), nominal(i + 1, 16'd0, "frame", i + 1));
    run_vectors();

    // ready low for 3 cycles while x=2,y=1 is presented (cycle 9)
    for (int i = 0; i <= FRAME_CYC + 5; i++) begin
      c  = i + 1;
      ec = (c <= 9) ? c : (c <= 12) ? 9 : c - 3;
      add(mk_in(1'b0, i == 0, 1'b0, !(i >= 9 && i <= 11)), nominal(ec, 16'd1, "stall", c));
    end
    run_vectors();

    // abort in the first HBLANK cycle after line 0
    d0 = done_cnt;
    for (int i = 0; i <= 7; i++) begin
      if (i < 5) add(mk_in(1'b0, i == 0, 1'b0, 1'b1), nominal(i + 1, 16'd2, "abort", i + 1));
      else       add(mk_in(1'b0, 1'b0, i == 5, 1'b1), idle_exp(16'd2, "abort", i + 1));
    end
    run_vectors();
    check("abort_no_done", done_cnt - d0, 0);

    // full frame after abort, with a stray start during the frame
    b0 = beat_cnt;
    d0 = done_cnt;
    for (int i = 0; i <= FRAME_CYC + 2; i++)
      add(mk_in(1'b0, i == 0 || i == 5, 1'b0, 1'b1), nominal(i + 1, 16'd2, "restart", i + 1));
    run_vectors();
    check("restart_beats", beat_cnt - b0, W * H);
    check("restart_dones", done_cnt - d0, 1);

    // reset while x=1,y=2 is presented (cycle 14)
    d0 = done_cnt;
    for (int i = 0; i <= 15; i++) begin
      if (i < 14) add(mk_in(1'b0, i == 0, 1'b0, 1'b1), nominal(i + 1, 16'd3, "midreset", i + 1));
      else        add(mk_in(i == 14, 1'b0, 1'b0, 1'b1), idle_exp(16'd0, "midreset", i + 1));
    end
    run_vectors();
    check("midreset_no_done", done_cnt - d0, 0);

    // start and abort together in IDLE
    b0 = beat_cnt;
    for (int i = 0; i <= 2; i++)
      add(mk_in(1'b0, i == 0, i == 0, 1'b1), idle_exp(16'd0, "start_abort", i + 1));
    run_vectors();
    check("start_abort_beats", beat_cnt - b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
